intersection_arbiter: RTL

INTERSECTION_ARBITER -- requirements
Module: intersection_arbiter

---
 rtl/intersection_arbiter_pkg.sv | 26 ++
 rtl/intersection_arbiter_if.sv | 23 ++
 rtl/intersection_arbiter_rr_picker.sv | 27 ++
 rtl/intersection_arbiter.sv | 103 ++++++++++
 4 files changed

// File: rtl/intersection_arbiter_pkg.sv
// Shared types and constants for the four-approach intersection arbiter.
package intersection_pkg;

  localparam int N_APPROACH = 4;

`ifdef FORMAL
  localparam logic [31:0] DEFAULT_GREEN_PERIOD = 32'd5;
  localparam logic [31:0] DEFAULT_CLEAR_PERIOD = 32'd2;
`else
  localparam logic [31:0] DEFAULT_GREEN_PERIOD = 32'd10000;
  localparam logic [31:0] DEFAULT_CLEAR_PERIOD = 32'd1000;
`endif

  typedef enum logic [1:0] {
    IDLE,
    GREEN,
    CLEAR
  } state_t;

  function automatic logic [N_APPROACH-1:0] approach_onehot(input logic [1:0] id);
    logic [N_APPROACH-1:0] one;
    one = {{(N_APPROACH-1){1'b0}}, 1'b1};
    return one << id;
  endfunction

endpackage

// File: rtl/intersection_arbiter_if.sv
// Request/inhibit inputs and light/status outputs of the arbiter.
interface intersection_arbiter_if;
  import intersection_pkg::*;

  logic [N_APPROACH-1:0] request;
  logic [N_APPROACH-1:0] blocked;
  logic [N_APPROACH-1:0] green;
  logic [N_APPROACH-1:0] red;
  logic [N_APPROACH-1:0] pending;
  logic [1:0]            grant_id;
  logic                  busy;

  modport master (
    output request, blocked,
    input  green, red, pending, grant_id, busy
  );

  modport slave (
    input  request, blocked,
    output green, red, pending, grant_id, busy
  );

endinterface

// File: rtl/intersection_arbiter_rr_picker.sv
// Combinational round-robin pick: first eligible index at or after pointer, wrapping 3->0.
module rr_picker
  import intersection_pkg::*;
(
  input  logic [N_APPROACH-1:0] eligible,
  input  logic [1:0]            pointer,
  output logic [1:0]            winner,
  output logic                  valid
);

  logic [1:0] idx;

  // Walk from farthest to nearest so the nearest eligible index is written last.
  always_comb begin
    winner = '0;
    valid  = 1'b0;
    idx    = '0;
    for (int k = N_APPROACH - 1; k >= 0; k--) begin
      idx = pointer + 2'(k);
      if (eligible[idx]) begin
        winner = idx;
        valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/intersection_arbiter.sv
// Round-robin traffic-light arbiter: IDLE -> GREEN (GREEN_PERIOD+1) -> CLEAR (CLEAR_PERIOD+1).
// Grant one edge after an eligible request in IDLE; later requests only queue as pending.
module intersection_arbiter
  import intersection_pkg::*;
#(
  parameter logic [31:0] GREEN_PERIOD = DEFAULT_GREEN_PERIOD,
  parameter logic [31:0] CLEAR_PERIOD = DEFAULT_CLEAR_PERIOD
) (
  input  logic                   clock,
  input  logic                   reset,
  intersection_arbiter_if.slave  bus
);

  state_t                state_q, state_d;
  logic [31:0]           cnt_q, cnt_d;
  logic [N_APPROACH-1:0] pending_q, pending_d;
  logic [N_APPROACH-1:0] green_q, green_d;
  logic [N_APPROACH-1:0] red_q, red_d;
  logic [1:0]            grant_id_q, grant_id_d;
  logic [1:0]            ptr_q, ptr_d;
  logic                  busy_q, busy_d;

  logic [N_APPROACH-1:0] eligible;
  logic [1:0]            winner;
  logic                  win_vld;

  assign eligible = (pending_q | bus.request) & ~bus.blocked;

  rr_picker u_picker (
    .eligible (eligible),
    .pointer  (ptr_q),
    .winner   (winner),
    .valid    (win_vld)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    grant_id_d = grant_id_q;
    ptr_d      = ptr_q;
    pending_d  = pending_q | bus.request;
    unique case (state_q)
      IDLE: begin
        if (win_vld) begin
          state_d            = GREEN;
          cnt_d              = GREEN_PERIOD;
          grant_id_d         = winner;
          ptr_d              = winner + 2'd1;
          // The grant consumes the winner's request, even one arriving this edge.
          pending_d[winner]  = 1'b0;
        end
      end
      GREEN: begin
        if (cnt_q == 32'd0) begin
          state_d = CLEAR;
          cnt_d   = CLEAR_PERIOD;
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end
      CLEAR: begin
        if (cnt_q == 32'd0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    green_d = (state_d == GREEN) ? approach_onehot(grant_id_d) : '0;
    red_d   = ~green_d;
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      pending_q  <= '0;
      green_q    <= '0;
      red_q      <= '1;
      grant_id_q <= '0;
      ptr_q      <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pending_q  <= pending_d;
      green_q    <= green_d;
      red_q      <= red_d;
      grant_id_q <= grant_id_d;
      ptr_q      <= ptr_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.green    = green_q;
  assign bus.red      = red_q;
  assign bus.pending  = pending_q;
  assign bus.grant_id = grant_id_q;
  assign bus.busy     = busy_q;

endmodule
